// File: rtl/tele_call_timers.sv
// Timer stage feeding the telephone call-control FSM.
// Two independent channels (dial, call). Each channel is a tick prescaler
// driving a saturating tick counter. The limit flags are decoded from
// registered counter state only, so no input reaches an output combinationally.
//
// Ports:
//   clk                      in   system clock, rising edge
//   reset_n                  in   asynchronous active-low reset
//   dial_counter_clear       in   clear dial prescaler and counter
//   dial_counter_increament  in   enable dial channel counting
//   call_counter_clear       in   clear call prescaler and counter
//   call_counter_increament  in   enable call channel counting
//   dial_count_5             out  dial count has reached DIAL_LIMIT
//   call_duration_count_250  out  call count has reached CALL_LIMIT
//   dial_secs                out  current dial tick count
//   call_secs                out  current call tick count

// One channel: a prescaler that wraps every TICK_DIV enabled cycles, and a
// counter that advances on each wrap until it saturates at LIMIT.
module tele_tick_counter #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned LIMIT    = 5,
  parameter int unsigned CNT_W    = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit_c
);

  localparam int unsigned PRE_W     = 32;
  localparam int unsigned TICK_LAST = TICK_DIV - 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: clear beats increment; the prescaler keeps cycling at saturation.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (inc) begin
      if (pre_q == PRE_W'(TICK_LAST)) begin
        pre_d = '0;
        if (cnt_q < CNT_W'(LIMIT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt        = cnt_q;
  assign at_limit_c = (cnt_q == CNT_W'(LIMIT));

endmodule

module tele_call_timers #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DIAL_LIMIT = 5,
  parameter int unsigned CALL_LIMIT = 250,
  parameter int unsigned CNT_W      = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dial_counter_clear,
  input  logic             dial_counter_increament,
  input  logic             call_counter_clear,
  input  logic             call_counter_increament,
  output logic             dial_count_5,
  output logic             call_duration_count_250,
  output logic [CNT_W-1:0] dial_secs,
  output logic [CNT_W-1:0] call_secs
);

  // Dial-timeout channel.
  tele_tick_counter #(
    .TICK_DIV (TICK_DIV),
    .LIMIT    (DIAL_LIMIT),
    .CNT_W    (CNT_W)
  ) u_dial (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (dial_counter_clear),
    .inc        (dial_counter_increament),
    .cnt        (dial_secs),
    .at_limit_c (dial_count_5)
  );

  // Call-duration channel.
  tele_tick_counter #(
    .TICK_DIV (TICK_DIV),
    .LIMIT    (CALL_LIMIT),
    .CNT_W    (CNT_W)
  ) u_call (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (call_counter_clear),
    .inc        (call_counter_increament),
    .cnt        (call_secs),
    .at_limit_c (call_duration_count_250)
  );

endmodule

// File: tb/tb_tele_call_timers.sv
// Bench for tele_call_timers: directed scenarios plus random strobes, checked
// every cycle against a model that counts enabled cycles since the last clear
// and derives the tick count as min(enabled / TICK_DIV, LIMIT).
module tb_tele_call_timers;

  localparam int unsigned TD = 4;
  localparam int unsigned DL = 5;
  localparam int unsigned CL = 250;
  localparam int unsigned W  = 9;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         dial_clr, dial_inc, call_clr, call_inc;
  logic         dial_count_5, call_duration_count_250;
  logic [W-1:0] dial_secs, call_secs;

  longint       dial_n, call_n;
  int           n_checks = 0;
  int           n_fails  = 0;

  always #5 clk = ~clk;

  tele_call_timers #(
    .TICK_DIV   (TD),
    .DIAL_LIMIT (DL),
    .CALL_LIMIT (CL),
    .CNT_W      (W)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .dial_counter_clear      (dial_clr),
    .dial_counter_increament (dial_inc),
    .call_counter_clear      (call_clr),
    .call_counter_increament (call_inc),
    .dial_count_5            (dial_count_5),
    .call_duration_count_250 (call_duration_count_250),
    .dial_secs               (dial_secs),
    .call_secs               (call_secs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint exp_cnt(input longint n, input longint lim);
    longint q;
    q = n / longint'(TD);
    return (q > lim) ? lim : q;
  endfunction

  task automatic compare_all();
    check("dial_secs", 32'(dial_secs), 32'(exp_cnt(dial_n, DL)));
    check("dial_flag", 32'(dial_count_5), 32'(exp_cnt(dial_n, DL) == DL));
    check("call_secs", 32'(call_secs), 32'(exp_cnt(call_n, CL)));
    check("call_flag", 32'(call_duration_count_250), 32'(exp_cnt(call_n, CL) == CL));
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then check.
  task automatic step();
    @(posedge clk);
    if (dial_clr) dial_n = 0; else if (dial_inc) dial_n++;
    if (call_clr) call_n = 0; else if (call_inc) call_n++;
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic dc, input logic di, input logic cc, input logic ci);
    dial_clr = dc;
    dial_inc = di;
    call_clr = cc;
    call_inc = ci;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    dial_n = 0;
    call_n = 0;
    #3;
    check("reset_dial_secs", 32'(dial_secs), 32'd0);
    check("reset_call_secs", 32'(call_secs), 32'd0);
    check("reset_dial_flag", 32'(dial_count_5), 32'd0);
    check("reset_call_flag", 32'(call_duration_count_250), 32'd0);
    #9 reset_n = 1'b1;

    // Reset in the middle of a count.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(14);
    check("s1_pre_reset", 32'(dial_secs), 32'd3);
    #2 reset_n = 1'b0;
    dial_n = 0;
    call_n = 0;
    #1;
    check("s1_async_secs", 32'(dial_secs), 32'd0);
    check("s1_async_flag", 32'(dial_count_5), 32'd0);
    #1 reset_n = 1'b1;
    run(19);
    check("s1_flag_e19", 32'(dial_count_5), 32'd0);
    run(1);
    check("s1_flag_e20", 32'(dial_count_5), 32'd1);

    // Dial timeout and saturation.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(4);
    check("s2_e4", 32'(dial_secs), 32'd1);
    run(16);
    check("s2_flag_e20", 32'(dial_count_5), 32'd1);
    run(20);
    check("s2_secs_e40", 32'(dial_secs), 32'd5);
    check("s2_flag_e40", 32'(dial_count_5), 32'd1);

    // Pause keeps the partial tick.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(6);
    check("s3_after_run", 32'(dial_secs), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    run(10);
    check("s3_paused", 32'(dial_secs), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(1);
    check("s3_e17", 32'(dial_secs), 32'd1);
    run(1);
    check("s3_e18", 32'(dial_secs), 32'd2);

    // Clear beats the tick edge, and resets the prescaler.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(3);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("s4_clr_wins", 32'(dial_secs), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(3);
    check("s4_pre_zeroed", 32'(dial_secs), 32'd0);
    run(1);
    check("s4_first_tick", 32'(dial_secs), 32'd1);
    run(16);
    check("s4_flag_set", 32'(dial_count_5), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("s4_flag_clr", 32'(dial_count_5), 32'd0);

    // Call limit with the dial channel idle.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    run(999);
    check("s5_flag_e999", 32'(call_duration_count_250), 32'd0);
    run(1);
    check("s5_flag_e1000", 32'(call_duration_count_250), 32'd1);
    check("s5_secs_e1000", 32'(call_secs), 32'd250);
    run(100);
    check("s5_secs_hold", 32'(call_secs), 32'd250);
    check("s5_flag_hold", 32'(call_duration_count_250), 32'd1);
    check("s5_dial_idle", 32'(dial_secs), 32'd0);

    // Dial held in clear while the call channel counts.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    run(500);
    check("s6_call_mid", 32'(call_secs), 32'd125);
    run(500);
    check("s6_call_end", 32'(call_secs), 32'd250);
    check("s6_dial_clr", 32'(dial_secs), 32'd0);

    // Random strobes on both channels.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 80),
            1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 85));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
